brew_sequencer: RTL and testbench

//  Downstream consumer of the clock divisor's one-cycle tick output. Sequences
//  one coffee cycle (heat, brew, optional milk, pour, done) by counting ticks
//  per stage. Drives the stage LEDs led[7:3] and a remaining-tick readout.

---
 rtl/brew_sequencer_pkg.sv | 33 +++
 rtl/brew_sequencer_stage_timer.sv | 34 +++
 rtl/brew_sequencer.sv | 126 ++++++++++++
 tb/tb_brew_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/brew_sequencer_pkg.sv
// Shared coffee-machine definitions: stage encodings, LED bit positions and the
// helper that turns a stage code into its one-hot LED pattern.
package brew_sequencer_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HEAT = 3'd1;
  localparam logic [2:0] ST_BREW = 3'd2;
  localparam logic [2:0] ST_MILK = 3'd3;
  localparam logic [2:0] ST_POUR = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  localparam int LED_HEAT = 3;
  localparam int LED_BREW = 4;
  localparam int LED_MILK = 5;
  localparam int LED_POUR = 6;
  localparam int LED_DONE = 7;

  // Unused encodings light nothing, so a corrupted state never shows a stage.
  function automatic logic [7:3] stage_led(input logic [2:0] st);
    logic [7:3] v;
    v = '0;
    case (st)
      ST_HEAT: v[LED_HEAT] = 1'b1;
      ST_BREW: v[LED_BREW] = 1'b1;
      ST_MILK: v[LED_MILK] = 1'b1;
      ST_POUR: v[LED_POUR] = 1'b1;
      ST_DONE: v[LED_DONE] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/brew_sequencer_stage_timer.sv
// Loadable down-counter that measures a stage in divisor ticks; expire flags the
// tick that ends the stage.
module stage_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             expire
);

  logic [CNT_W-1:0] r_cnt;

  // clr beats load beats tick: aborts win, and a stage change reloads rather than decrements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (tick && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign cnt    = r_cnt;
  assign expire = tick && (r_cnt == CNT_W'(1));

endmodule

// File: rtl/brew_sequencer.sv
// Coffee-cycle sequencer: walks HEAT, BREW, optional MILK, POUR and DONE, holding
// each stage for a fixed number of divisor ticks.
module brew_sequencer
  import brew_sequencer_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int HEAT_T = 5,
  parameter int BREW_T = 10,
  parameter int MILK_T = 4,
  parameter int POUR_T = 3,
  parameter int DONE_T = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             start,
  input  logic             cancel,
  input  logic [1:0]       sel,
  output logic             busy,
  output logic             done,
  output logic [7:3]       led,
  output logic [CNT_W-1:0] secs_left
);

  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  function automatic logic [CNT_W-1:0] sat_dur(input longint unsigned v);
    if (v > CNT_MAX) return '1;
    return CNT_W'(v);
  endfunction

  localparam logic [CNT_W-1:0] HEAT_DUR  = sat_dur(longint'(HEAT_T));
  localparam logic [CNT_W-1:0] BREW_DUR  = sat_dur(longint'(BREW_T));
  localparam logic [CNT_W-1:0] BREW_LONG = sat_dur(2 * longint'(BREW_T));
  localparam logic [CNT_W-1:0] MILK_DUR  = sat_dur(longint'(MILK_T));
  localparam logic [CNT_W-1:0] POUR_DUR  = sat_dur(longint'(POUR_T));
  localparam logic [CNT_W-1:0] DONE_DUR  = sat_dur(longint'(DONE_T));

  logic [2:0]       r_state;
  logic [1:0]       r_sel_q;
  logic [2:0]       w_next;
  logic             w_load;
  logic             w_clr;
  logic             w_latch_sel;
  logic [CNT_W-1:0] w_load_val;
  logic [CNT_W-1:0] w_cnt;
  logic             w_expire;

  stage_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .load_val (w_load_val),
    .tick     (tick),
    .clr      (w_clr),
    .cnt      (w_cnt),
    .expire   (w_expire)
  );

  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_clr       = 1'b0;
    w_latch_sel = 1'b0;
    w_load_val  = '0;
    if (r_state == ST_IDLE) begin
      if (start && !cancel) begin
        w_next      = ST_HEAT;
        w_load      = 1'b1;
        w_load_val  = HEAT_DUR;
        w_latch_sel = 1'b1;
      end
    end else if (cancel) begin
      w_next = ST_IDLE;
      w_clr  = 1'b1;
    end else begin
      case (r_state)
        ST_HEAT: if (w_expire) begin
          w_next     = ST_BREW;
          w_load     = 1'b1;
          w_load_val = r_sel_q[1] ? BREW_LONG : BREW_DUR;
        end
        ST_BREW: if (w_expire) begin
          w_next     = r_sel_q[0] ? ST_MILK : ST_POUR;
          w_load     = 1'b1;
          w_load_val = r_sel_q[0] ? MILK_DUR : POUR_DUR;
        end
        ST_MILK: if (w_expire) begin
          w_next     = ST_POUR;
          w_load     = 1'b1;
          w_load_val = POUR_DUR;
        end
        ST_POUR: if (w_expire) begin
          w_next     = ST_DONE;
          w_load     = 1'b1;
          w_load_val = DONE_DUR;
        end
        ST_DONE: if (w_expire) begin
          w_next = ST_IDLE;
          w_clr  = 1'b1;
        end
        default: begin
          w_next = ST_IDLE;
          w_clr  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sel_q <= 2'b00;
    end else begin
      r_state <= w_next;
      if (w_latch_sel) r_sel_q <= sel;
    end
  end

  // Outputs come straight off the state and counter registers, so they change with the state.
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign led       = stage_led(r_state);
  assign secs_left = w_cnt;

endmodule

// File: tb/tb_brew_sequencer.sv
// Directed bench for brew_sequencer with a cycle-level reference model feeding
// a scoreboard of expected outputs.
module tb_brew_sequencer;

  localparam int CNT_W  = 8;
  localparam int HEAT_T = 3;
  localparam int BREW_T = 4;
  localparam int MILK_T = 2;
  localparam int POUR_T = 2;
  localparam int DONE_T = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             tick, start, cancel;
  logic [1:0]       sel;
  logic             busy, done;
  logic [4:0]       led;
  logic [CNT_W-1:0] secs_left;

  typedef struct {
    logic [4:0]       led;
    logic [CNT_W-1:0] secs;
    logic             busy;
    logic             done;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: stage 0=idle 1=heat 2=brew 3=milk 4=pour 5=done.
  int         m_stage = 0;
  int         m_cnt   = 0;
  logic [1:0] m_sel   = 2'b00;

  int   seen_milk;
  int   max_brew;
  int   n;

  brew_sequencer #(
    .CNT_W(CNT_W), .HEAT_T(HEAT_T), .BREW_T(BREW_T),
    .MILK_T(MILK_T), .POUR_T(POUR_T), .DONE_T(DONE_T)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .start     (start),
    .cancel    (cancel),
    .sel       (sel),
    .busy      (busy),
    .done      (done),
    .led       (led),
    .secs_left (secs_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int dur_of(input int st);
    case (st)
      1: return HEAT_T;
      2: return m_sel[1] ? 2 * BREW_T : BREW_T;
      3: return MILK_T;
      4: return POUR_T;
      5: return DONE_T;
      default: return 0;
    endcase
  endfunction

  function automatic int next_of(input int st);
    case (st)
      1: return 2;
      2: return m_sel[0] ? 3 : 4;
      3: return 4;
      4: return 5;
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input logic t, input logic s, input logic c);
    if (m_stage == 0) begin
      if (s && !c) begin
        m_stage = 1;
        m_sel   = sel;
        m_cnt   = HEAT_T;
      end
    end else if (c) begin
      m_stage = 0;
      m_cnt   = 0;
    end else if (t) begin
      if (m_cnt == 1) begin
        m_stage = next_of(m_stage);
        m_cnt   = dur_of(m_stage);
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.led  = (m_stage == 0) ? 5'b00000 : 5'(1 << (m_stage - 1));
    e.secs = CNT_W'(m_cnt);
    e.busy = (m_stage != 0);
    e.done = (m_stage == 5);
    return e;
  endfunction

  task automatic cyc(input logic t, input logic s, input logic c);
    exp_t e;
    @(negedge clk);
    tick = t; start = s; cancel = c;
    model_step(t, s, c);
    q.push_back(model_out());
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("led", 32'(led), 32'(e.led));
    chk("secs_left", 32'(secs_left), 32'(e.secs));
    chk("busy", 32'(busy), 32'(e.busy));
    chk("done", 32'(done), 32'(e.done));
    if (led === 5'b00100) seen_milk++;
    if (led === 5'b00010 && int'(secs_left) > max_brew) max_brew = int'(secs_left);
  endtask

  task automatic tick_period();
    cyc(1'b1, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_until_idle(output int cnt_ticks);
    cnt_ticks = 0;
    do begin
      tick_period();
      cnt_ticks++;
    end while (busy && cnt_ticks < 40);
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; start = 1'b0; cancel = 1'b0; sel = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_secs", 32'(secs_left), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);

    // Plain cycle: no milk, normal brew.
    sel = 2'b00; seen_milk = 0; max_brew = 0;
    cyc(1'b0, 1'b1, 1'b0);
    chk("plain_heat_load", 32'(secs_left), 32'd3);
    run_until_idle(n);
    chk("plain_busy_ticks", 32'(n), 32'd11);
    chk("plain_no_milk", 32'(seen_milk), 32'd0);
    chk("plain_brew_len", 32'(max_brew), 32'd4);

    // Milk and long brew.
    sel = 2'b11; seen_milk = 0; max_brew = 0;
    cyc(1'b0, 1'b1, 1'b0);
    sel = 2'b00;
    run_until_idle(n);
    chk("long_busy_ticks", 32'(n), 32'd17);
    chk("long_brew_len", 32'(max_brew), 32'd8);
    chk("long_milk_seen", 32'(seen_milk > 0), 32'd1);

    // Cancel in BREW with a coincident tick, then an immediate restart.
    cyc(1'b0, 1'b1, 1'b0);
    repeat (5) tick_period();
    chk("cancel_pre_led", 32'(led), 32'h02);
    chk("cancel_pre_secs", 32'(secs_left), 32'd2);
    cyc(1'b1, 1'b0, 1'b1);
    chk("cancel_led", 32'(led), 32'd0);
    chk("cancel_busy", 32'(busy), 32'd0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("restart_secs", 32'(secs_left), 32'd3);
    chk("restart_led", 32'(led), 32'h01);

    // Start while in POUR is ignored.
    repeat (7) tick_period();
    chk("pour_led", 32'(led), 32'h08);
    cyc(1'b0, 1'b1, 1'b0);
    chk("pour_ignore_led", 32'(led), 32'h08);
    chk("pour_ignore_secs", 32'(secs_left), 32'd2);
    run_until_idle(n);
    chk("pour_tail_ticks", 32'(n), 32'd4);
    cyc(1'b0, 1'b1, 1'b1);
    chk("idle_start_cancel_busy", 32'(busy), 32'd0);
    chk("idle_start_cancel_led", 32'(led), 32'd0);

    // Tick coincident with start is not counted.
    cyc(1'b1, 1'b1, 1'b0);
    chk("tick_start_secs", 32'(secs_left), 32'd3);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    chk("tick_start_hold", 32'(secs_left), 32'd3);
    cyc(1'b1, 1'b0, 1'b0);
    chk("tick_start_next", 32'(secs_left), 32'd2);

    // Asynchronous reset in the middle of a cycle.
    repeat (4) tick_period();
    chk("midrun_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    chk("async_rst_led", 32'(led), 32'd0);
    chk("async_rst_secs", 32'(secs_left), 32'd0);
    m_stage = 0; m_cnt = 0; m_sel = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
